store_merge_ctrl: RTL

//  Store-side partner of the load half-word select/sign-extend path: writes word, half-word
//  and (optionally) byte stores into a word-wide data RAM that has no byte enables.

---
 rtl/store_pkg.sv | 37 +++
 rtl/store_merge_ctrl_lane_merge.sv | 53 +++++
 rtl/store_merge_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared types and constants for the store-merge path: size codes, FSM states, lane selects.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: size_e (SZ_WORD/SZ_HALF/SZ_BYTE/SZ_RSVD), state_e (ST_IDLE/ST_WR/ST_RD/ST_MRG/ST_ERR),
// lane-width and lane-select constants used by lane_merge and store_merge_ctrl.
package store_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;

  // Byte-address bit that picks the upper half-word within a RAM word.
  localparam int HALF_SEL_BIT = 1;

  // Byte-lane indices within a little-endian RAM word.
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_MRG  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/store_merge_ctrl_lane_merge.sv
// lane_merge: splices a half-word (or byte) of new store data into an old RAM word.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   old_word_i  [31:0]  word read back from RAM
//   new_data_i  [15:0]  store data, sub-word value in the low bits
//   size_i      size_e  store size; SZ_WORD/SZ_RSVD pass old_word_i through
//   lane_i      [1:0]   byte address within the word
//   merged_o    [31:0]  word to write back
// Byte lanes exist only when STORE_MERGE_BYTE_EN is defined.
module lane_merge
  import store_pkg::*;
(
  input  logic [WORD_W-1:0] old_word_i,
  input  logic [HALF_W-1:0] new_data_i,
  input  size_e             size_i,
  input  logic [1:0]        lane_i,
  output logic [WORD_W-1:0] merged_o
);

`ifndef STORE_MERGE_BYTE_EN
  // Half-word selection only looks at bit 1; bit 0 matters only to byte lanes.
  logic unused_lane0;
  assign unused_lane0 = lane_i[0];
`endif

  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_HALF: begin
        if (lane_i[HALF_SEL_BIT]) begin
          merged_o[WORD_W-1:HALF_W] = new_data_i;
        end else begin
          merged_o[HALF_W-1:0] = new_data_i;
        end
      end
`ifdef STORE_MERGE_BYTE_EN
      SZ_BYTE: begin
        case (lane_i)
          LANE_B0: merged_o[7:0]   = new_data_i[BYTE_W-1:0];
          LANE_B1: merged_o[15:8]  = new_data_i[BYTE_W-1:0];
          LANE_B2: merged_o[23:16] = new_data_i[BYTE_W-1:0];
          LANE_B3: merged_o[31:24] = new_data_i[BYTE_W-1:0];
          default: merged_o = old_word_i;
        endcase
      end
`endif
      default: merged_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/store_merge_ctrl.sv
// store_merge_ctrl: commits word/half/byte stores to a RAM without byte enables (RMW for sub-word).
// Latency: word store writes 1 cycle after accept, sub-word 2 cycles after accept, error pulse 1.
// Backpressure: req_ready high only in IDLE; one store in flight, a held request waits for IDLE.
//
// Optional feature macro: STORE_MERGE_BYTE_EN (byte stores via RMW; otherwise size 10 -> err).
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   req_valid/req_ready      store handshake; req_addr[31:0] byte address,
//                            req_data[31:0] store data, req_size[1:0] size code
//   mem_addr[ADDR_W-1:0]     RAM word address (req_addr[ADDR_W+1:2], wraps)
//   mem_re / mem_rdata       read strobe; read data returns the following cycle
//   mem_we / mem_wdata       write strobe and data
//   done / err               one-cycle pulses: store committed / request dropped
module store_merge_ctrl
  import store_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  size_e             size_q, size_d;

  logic  accept;
  logic  bad_req;
  size_e req_size_e;
  logic [31:0] merged;

  // Bits above the RAM range are dropped so out-of-range addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_size_e = size_e'(req_size);
  assign accept     = req_valid & req_ready;

  // Decode of requests that must be dropped with an err pulse.
  always_comb begin
    bad_req = 1'b0;
    case (req_size_e)
      SZ_WORD: bad_req = (req_addr[1:0] != 2'b00);
      SZ_HALF: bad_req = req_addr[0];
`ifdef STORE_MERGE_BYTE_EN
      SZ_BYTE: bad_req = 1'b0;
`else
      SZ_BYTE: bad_req = 1'b1;
`endif
      default: bad_req = 1'b1;
    endcase
  end

  // Request latch: RAM-facing outputs never look at req_* directly.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    size_d = size_q;
    if (accept) begin
      addr_d = req_addr[ADDR_W+1:0];
      data_d = req_data;
      size_d = req_size_e;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (bad_req) begin
            state_d = ST_ERR;
          end else if (req_size_e == SZ_WORD) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD:   state_d = ST_MRG;
      ST_WR:   state_d = ST_IDLE;
      ST_MRG:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= SZ_WORD;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
    end
  end

  // In MRG, mem_rdata carries the word requested by RD in the previous cycle.
  lane_merge u_lane_merge (
    .old_word_i (mem_rdata),
    .new_data_i (data_q[HALF_W-1:0]),
    .size_i     (size_q),
    .lane_i     (addr_q[1:0]),
    .merged_o   (merged)
  );

  // Strobes decode straight from state_q so a reset removes them without waiting for a clock.
  always_comb begin
    req_ready = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_WR: begin
        mem_we    = 1'b1;
        mem_wdata = data_q;
        done      = 1'b1;
      end
      ST_RD:   mem_re = 1'b1;
      ST_MRG: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        done      = 1'b1;
      end
      ST_ERR:  err = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  assign mem_addr = addr_q[ADDR_W+1:2];

endmodule
